// File: rtl/muldiv_hilo_if.sv
// muldiv_hilo_if
//   Bundles the EX-stage request side and the HI/LO result side of the
//   iterative multiply/divide unit.
//
//   master (EX stage / pipeline control) drives:
//     start, op[1:0], a, b     operation issue and operands
//     mthi, mtlo, wdata        direct HI/LO writes
//     flush                    kill in-progress or issuing operation
//   slave (muldiv_hilo) drives:
//     busy, stall_req, done    status / pipeline hold
//     hiwrite, lowrite         HI/LO written at end of this cycle
//     hi_next, lo_next         value being written (forwarding source)
//     hi, lo                   architectural HI/LO registers
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             flush;

    logic             busy;
    logic             stall_req;
    logic             done;
    logic             hiwrite;
    logic             lowrite;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata, flush,
        input  busy, stall_req, done, hiwrite, lowrite,
               hi_next, lo_next, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata, flush,
        output busy, stall_req, done, hiwrite, lowrite,
               hi_next, lo_next, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo.sv
// muldiv_hilo
//   Iterative multiply/divide unit owning the architectural HI/LO registers.
//   Accepts MULT/MULTU/DIV/DIVU (op 00/01/10/11) and MTHI/MTLO. Multiply is
//   radix-2 shift-add, divide is restoring; both work on operand magnitudes
//   over WIDTH RUN cycles, then a single FIX cycle applies sign correction
//   and commits HI/LO. hiwrite/lowrite with hi_next/lo_next expose the value
//   being committed so the hazard logic can forward it.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset (IDLE, HI = LO = 0)
//     bus   muldiv_hilo_if.slave (start/op/a/b/mthi/mtlo/wdata/flush in;
//           busy/stall_req/done/hiwrite/lowrite/hi_next/lo_next/hi/lo out)
//
//   Build option:
//     MULDIV_FAST_MUL_EN  when defined, MULT/MULTU use a single-cycle
//                         combinational multiply (IDLE -> FIX directly).
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_hilo_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]         state_q,    state_d;
    logic [1:0]         op_q,       op_d;
    logic [CW-1:0]      cnt_q,      cnt_d;
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q,      acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]   opb_q,      opb_d;
    logic               neg_res_q,  neg_res_d;
    logic               neg_rem_q,  neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q,       hi_d;
    logic [WIDTH-1:0]   lo_q,       lo_d;

    // Issue-side decode
    logic               is_idle;
    logic               accept;
    logic               op_signed;
    logic               op_is_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    // One iteration of each algorithm
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shl;
    logic [WIDTH:0]     div_diff;
    logic               q_bit;
    logic [2*WIDTH-1:0] div_step;

    // FIX-cycle results
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Write strobes
    logic               commit;
    logic               mthi_eff;
    logic               mtlo_eff;

    always_comb begin
        is_idle   = (state_q == ST_IDLE);
        accept    = is_idle & bus.start & ~bus.flush;
        op_signed = ~bus.op[0];
        op_is_div = bus.op[1];
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        abs_a     = a_neg ? (-bus.a) : bus.a;
        abs_b     = b_neg ? (-bus.b) : bus.b;
    end

    always_comb begin
        mul_add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step = {mul_add, acc_q[WIDTH-1:1]};

        // The shifted remainder is always below twice the divisor, so a
        // non-negative difference always fits back into WIDTH bits.
        div_shl  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_shl - {1'b0, opb_q};
        q_bit    = ~div_diff[WIDTH];
        div_step = {(q_bit ? div_diff[WIDTH-1:0] : div_shl[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        mul_res = neg_res_q ? (-acc_q) : acc_q;
        // With a zero divisor the restoring loop leaves quotient all ones and
        // remainder |a|; re-applying a's sign to the remainder yields a, so
        // only the quotient needs an override.
        q_fix   = div_zero_q ? '1
                : (neg_res_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
        r_fix   = neg_rem_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        fix_hi  = op_q[1] ? r_fix : mul_res[2*WIDTH-1:WIDTH];
        fix_lo  = op_q[1] ? q_fix : mul_res[WIDTH-1:0];
    end

    always_comb begin
        commit   = (state_q == ST_FIX) & ~bus.flush & ~rst;
        mthi_eff = is_idle & ~bus.start & ~bus.flush & ~rst & bus.mthi;
        mtlo_eff = is_idle & ~bus.start & ~bus.flush & ~rst & bus.mtlo;

        bus.done      = commit;
        bus.hiwrite   = commit | mthi_eff;
        bus.lowrite   = commit | mtlo_eff;
        bus.hi_next   = commit ? fix_hi : (mthi_eff ? bus.wdata : hi_q);
        bus.lo_next   = commit ? fix_lo : (mtlo_eff ? bus.wdata : lo_q);
        bus.hi        = hi_q;
        bus.lo        = lo_q;
        bus.busy      = ~is_idle;
        bus.stall_req = (state_q == ST_RUN) | accept;

        hi_d = bus.hi_next;
        lo_d = bus.lo_next;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_RUN;
                    op_d       = bus.op;
                    cnt_d      = CW'(WIDTH - 1);
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = (bus.b == '0);
                    opb_d      = op_is_div ? abs_b : abs_a;
                    acc_d      = {{WIDTH{1'b0}}, (op_is_div ? abs_a : abs_b)};
`ifdef MULDIV_FAST_MUL_EN
                    if (!op_is_div) begin
                        state_d = ST_FIX;
                        acc_d   = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
                    end
`endif
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = op_q[1] ? div_step : mul_step;
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk;
    logic rst;

    muldiv_hilo_if #(.WIDTH(W)) bus ();

    muldiv_hilo #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[12];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input string name);
        int lat    = 0;
        int stalls = 0;
        int exp_lat;
        bit seen   = 1'b0;
        exp_lat = (FAST && !op[1]) ? 1 : W + 1;
        next_cycle();
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        #1;
        if (bus.stall_req) stalls++;
        for (int i = 0; i < 200 && !seen; i++) begin
            next_cycle();
            bus.start = 1'b0;
            #1;
            lat++;
            if (bus.stall_req) stalls++;
            if (bus.done) begin
                seen = 1'b1;
                chk($sformatf("%s hi_next", name), bus.hi_next, ehi);
                chk($sformatf("%s lo_next", name), bus.lo_next, elo);
                chk($sformatf("%s hiwrite", name), W'(bus.hiwrite), W'(1));
                chk($sformatf("%s lowrite", name), W'(bus.lowrite), W'(1));
                chk($sformatf("%s busy_at_done", name), W'(bus.busy), W'(1));
            end
        end
        chk($sformatf("%s done_seen", name), W'(seen), W'(1));
        chk($sformatf("%s latency", name), W'(lat), W'(exp_lat));
        chk($sformatf("%s stall_cycles", name), W'(stalls), W'(exp_lat));
        next_cycle();
        #1;
        chk($sformatf("%s hi", name), bus.hi, ehi);
        chk($sformatf("%s lo", name), bus.lo, elo);
        chk($sformatf("%s busy_after", name), W'(bus.busy), W'(0));
    endtask

    task automatic mt_write(input logic hi_sel, input logic [W-1:0] val);
        next_cycle();
        bus.mthi  = hi_sel;
        bus.mtlo  = ~hi_sel;
        bus.wdata = val;
        #1;
        next_cycle();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
    endtask

    int dones;

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[9]  = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[10] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        bus.flush = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        chk("reset hi", bus.hi, 32'h0);
        chk("reset lo", bus.lo, 32'h0);
        chk("reset busy", W'(bus.busy), W'(0));
        chk("reset done", W'(bus.done), W'(0));
        chk("reset hiwrite", W'(bus.hiwrite), W'(0));
        chk("reset stall_req", W'(bus.stall_req), W'(0));
        chk("reset hi_next", bus.hi_next, 32'h0);

        // MTHI: strobe in the same cycle, register next cycle, LO untouched
        next_cycle();
        bus.mthi  = 1'b1;
        bus.wdata = 32'h12345678;
        #1;
        chk("mthi hiwrite", W'(bus.hiwrite), W'(1));
        chk("mthi lowrite", W'(bus.lowrite), W'(0));
        chk("mthi hi_next", bus.hi_next, 32'h12345678);
        chk("mthi lo_next", bus.lo_next, 32'h0);
        next_cycle();
        bus.mthi = 1'b0;
        #1;
        chk("mthi hi", bus.hi, 32'h12345678);
        chk("mthi lo", bus.lo, 32'h0);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   $sformatf("vec%0d", i));
        end

        // Known HI/LO before the flush test
        mt_write(1'b1, 32'hAAAA5555);
        mt_write(1'b0, 32'h0F0F0F0F);
        #1;
        chk("mt setup hi", bus.hi, 32'hAAAA5555);
        chk("mt setup lo", bus.lo, 32'h0F0F0F0F);

        // Flush in RUN cycle 10
        dones = 0;
        next_cycle();
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            bus.start = 1'b0;
            #1;
            if (bus.done) dones++;
        end
        next_cycle();
        bus.flush = 1'b1;
        #1;
        chk("flush busy_in_run", W'(bus.busy), W'(1));
        if (bus.done) dones++;
        next_cycle();
        bus.flush = 1'b0;
        #1;
        chk("flush busy_next", W'(bus.busy), W'(0));
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            #1;
            if (bus.done) dones++;
        end
        chk("flush done_count", W'(dones), W'(0));
        chk("flush hi", bus.hi, 32'hAAAA5555);
        chk("flush lo", bus.lo, 32'h0F0F0F0F);

        // start held through the whole operation: one accept, one done
        dones = 0;
        next_cycle();
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        for (int i = 0; i < W + 1; i++) begin
            next_cycle();
            bus.a = 32'd5;
            bus.b = 32'd1;
            #1;
            if (bus.done) dones++;
        end
        next_cycle();
        bus.start = 1'b0;
        #1;
        if (bus.done) dones++;
        for (int i = 0; i < 2 * W + 10; i++) begin
            next_cycle();
            #1;
            if (bus.done) dones++;
        end
        chk("held done_count", W'(dones), W'(1));
        chk("held hi", bus.hi, 32'd2);
        chk("held lo", bus.lo, 32'd14);

        // Reset mid-operation
        next_cycle();
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd50;
        bus.b     = 32'd5;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            bus.start = 1'b0;
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        chk("midrst busy", W'(bus.busy), W'(0));
        chk("midrst stall_req", W'(bus.stall_req), W'(0));
        chk("midrst hi", bus.hi, 32'h0);
        chk("midrst lo", bus.lo, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
